// File: rtl/mdu_ctrl.sv
// MDU controller: sequences fixed-latency mult/div and owns the HI/LO registers.
// Optional `MDU_DIVZERO_FAST_EN` makes divide-by-zero complete without entering RUN.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  mlu_op,
    input  logic [2:0]  mlu_out,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        d_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW_RAW     = $clog2(MAX_CYCLES + 1);
    localparam int CW         = (CW_RAW < 4) ? 4 : CW_RAW;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [4:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;

    logic is_md_op;
    logic is_div_op;
    logic run_op;
    logic acc;

    assign is_md_op  = (mlu_op >= 5'd1) && (mlu_op <= 5'd4);
    assign is_div_op = (mlu_op == 5'd3) || (mlu_op == 5'd4);

`ifdef MDU_DIVZERO_FAST_EN
    assign run_op = is_md_op && !(is_div_op && (rt_val == 32'd0));
`else
    assign run_op = is_md_op;
`endif

    assign busy     = (state == RUN);
    assign acc      = start && !flush && !busy;
    assign stall_md = d_md && ((start && !flush && run_op) || busy);

    // Result datapath works on the latched operands, so rs/rt may change during RUN.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_sdiv;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
    assign is_sdiv = (op_q == 5'd3);
    assign neg_a   = is_sdiv && a_q[31];
    assign neg_b   = is_sdiv && b_q[31];
    assign mag_a   = neg_a ? (~a_q + 32'd1) : a_q;
    assign mag_b   = neg_b ? (~b_q + 32'd1) : b_q;
    // Signed divide via magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    assign quo_u   = mag_a / mag_b;
    assign rem_u   = mag_a % mag_b;
    assign quo     = (neg_a ^ neg_b) ? (~quo_u + 32'd1) : quo_u;
    assign rem     = neg_a ? (~rem_u + 32'd1) : rem_u;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == IDLE) begin
            if (acc) begin
                if (run_op) begin
                    op_q  <= mlu_op;
                    a_q   <= rs_val;
                    b_q   <= rt_val;
                    cnt   <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state <= RUN;
                end else if (mlu_op == 5'd5) begin
                    hi <= rs_val;
                end else if (mlu_op == 5'd6) begin
                    lo <= rs_val;
                end
            end
        end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state <= IDLE;
                if (op_q == 5'd1) begin
                    hi <= prod_s[63:32];
                    lo <= prod_s[31:0];
                end else if (op_q == 5'd2) begin
                    hi <= prod_u[63:32];
                    lo <= prod_u[31:0];
                end else if (b_q != 32'd0) begin
                    hi <= rem;
                    lo <= quo;
                end
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (mlu_out)
            3'd1:    rd_data = hi;
            3'd2:    rd_data = lo;
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes reference results, monitor checks every cycle.
// Honours `MDU_DIVZERO_FAST_EN` the same way as the design.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  mlu_op = '0;
    logic [2:0]  mlu_out = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        d_md = 1'b0;
    logic        busy;
    logic        stall_md;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .mlu_op(mlu_op), .mlu_out(mlu_out),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .d_md(d_md),
        .busy(busy), .stall_md(stall_md), .rd_data(rd_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          wh;
        bit          wl;
        logic [31:0] hv;
        logic [31:0] lv;
    } exp_t;

    exp_t q[$];
    int   busy_from = 1;
    int   busy_until = 0;
    int   errors = 0;
    int   checks = 0;

`ifdef MDU_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit occupies(input logic [4:0] op, input logic [31:0] rt);
        if (op < 5'd1 || op > 5'd4) return 1'b0;
        if (FAST && (op == 5'd3 || op == 5'd4) && rt == 32'd0) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: applies due results to its own HI/LO view and checks all outputs each cycle.
    logic [31:0] mon_hi = '0;
    logic [31:0] mon_lo = '0;
    initial begin
        exp_t e;
        bit   bexp;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_hi = '0;
                mon_lo = '0;
            end else begin
                while (q.size() > 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    if (e.wh) mon_hi = e.hv;
                    if (e.wl) mon_lo = e.lv;
                end
            end
            bexp = !reset && (cyc >= busy_from) && (cyc <= busy_until);
            chk("busy", {31'd0, busy}, {31'd0, bexp});
            chk("hi", hi, mon_hi);
            chk("lo", lo, mon_lo);
            chk("rd_data", rd_data, (mlu_out == 3'd1) ? mon_hi : (mlu_out == 3'd2) ? mon_lo : 32'd0);
            chk("stall_md", {31'd0, stall_md},
                {31'd0, d_md && ((start && !flush && occupies(mlu_op, rt_val)) || bexp)});
        end
    end

    task automatic rand_side();
        d_md    = 1'($urandom_range(0, 1));
        mlu_out = 3'($urandom_range(0, 7));
    endtask

    // Idle until the next cycle is free; stray starts land only in busy cycles and must be ignored.
    task automatic wait_free();
        while (cyc + 1 >= busy_from && cyc + 1 <= busy_until) begin
            @(posedge clk); #1;
            start  = ($urandom_range(0, 3) == 0);
            mlu_op = 5'($urandom_range(0, 7));
            rs_val = $urandom;
            rt_val = $urandom;
            flush  = 1'($urandom_range(0, 1));
            rand_side();
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit fl);
        exp_t   e;
        int     len;
        longint x, y, p;
        logic [63:0] pu;
        wait_free();
        @(posedge clk); #1;
        start = 1'b1; mlu_op = op; rs_val = a; rt_val = b; flush = fl;
        rand_side();
        if (!fl) begin
            e.wh = 0; e.wl = 0; e.hv = '0; e.lv = '0; len = 0;
            case (op)
                5'd1: begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    e.wh = 1; e.wl = 1; e.hv = p[63:32]; e.lv = p[31:0]; len = MULT_N;
                end
                5'd2: begin
                    pu = {32'd0, a} * {32'd0, b};
                    e.wh = 1; e.wl = 1; e.hv = pu[63:32]; e.lv = pu[31:0]; len = MULT_N;
                end
                5'd3, 5'd4: begin
                    if (b == 32'd0) len = FAST ? 0 : DIV_N;
                    else begin
                        len = DIV_N;
                        e.wh = 1; e.wl = 1;
                        if (op == 5'd3) begin
                            x = longint'($signed(a));
                            y = longint'($signed(b));
                            p = x / y; e.lv = p[31:0];
                            p = x % y; e.hv = p[31:0];
                        end else begin
                            e.lv = a / b;
                            e.hv = a % b;
                        end
                    end
                end
                5'd5: begin e.wh = 1; e.hv = a; end
                5'd6: begin e.wl = 1; e.lv = a; end
                default: ;
            endcase
            e.due = cyc + 1 + len;
            q.push_back(e);
            if (len > 0) begin
                busy_from  = cyc + 1;
                busy_until = cyc + len;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
        rand_side();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        q.delete();
        busy_from = 1; busy_until = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        issue(5'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        issue(5'd4, 32'd100, 32'd7, 1'b0);
        issue(5'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(5'd5, 32'h1234_5678, 32'd0, 1'b0);
        issue(5'd1, 32'd3, 32'd4, 1'b1);
        issue(5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(5'd5, 32'h0000_000A, 32'd0, 1'b0);
        issue(5'd6, 32'h0000_000B, 32'd0, 1'b0);
        issue(5'd3, 32'd55, 32'd0, 1'b0);
        issue(5'd4, 32'd77, 32'd0, 1'b0);
        issue(5'd7, 32'd1, 32'd2, 1'b0);
        issue(5'd3, 32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        do_reset();

        for (int i = 0; i < 250; i++) begin
            op = 5'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 31);
            issue(op, a, b, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 40) == 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_reset();
            end
        end

        for (int k = 0; k < 200 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
